// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BCD_MAX  = 9999;
  localparam int BIN_W    = 14;
  localparam int BCD_ITER = 14;
  localparam int BCD_W    = 16;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    code = SEG_BLANK;
    case (digit)
      4'd0: code = SEG_0;
      4'd1: code = SEG_1;
      4'd2: code = SEG_2;
      4'd3: code = SEG_3;
      4'd4: code = SEG_4;
      4'd5: code = SEG_5;
      4'd6: code = SEG_6;
      4'd7: code = SEG_7;
      4'd8: code = SEG_8;
      4'd9: code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, 14 steps after start.
// done is high in the cycle of the final step; bcd then carries that step's result.
module bin_to_bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       iter_q;
  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < 4; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  // Next value of the BCD accumulator after this cycle's step.
  assign bcd  = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign done = busy && (iter_q == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      bin_q  <= operand;
      bcd_q  <= '0;
      iter_q <= 4'(BCD_ITER);
      busy   <= 1'b1;
    end else if (busy) begin
      bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
      bcd_q  <= bcd;
      iter_q <= iter_q - 4'd1;
      if (iter_q == 4'd1) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin sharing of one four-digit display between NUM_CH producers:
// grant one sample, convert it to BCD, show it for DWELL cycles, repeat.
module display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DWELL  = 50000000,
  parameter int CH_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [16*NUM_CH-1:0] req_data,
  output logic [NUM_CH-1:0]    req_ready,
  input  logic                 freeze,
  output logic [15:0]          bcd_out,
  output logic [CH_W-1:0]      chan_id,
  output logic                 disp_update,
  output logic                 overflow,
  output state_t               fsm_state
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ptr_q, grant_idx, chan_pend_q;
  logic             ovf_pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant;
  logic [15:0]      sample;
  logic [BIN_W-1:0] operand;
  logic             conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;
  int               cand;

  // Valid/ready: a transfer happens on a rising edge where req_valid[i] and
  // req_ready[i] are both high; ready is one-hot and only ever raised in ARB.
  always_comb begin
    grant_idx = '0;
    cand      = 0;
    // Walk from the farthest offset down so the nearest valid after ptr wins.
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = (int'(ptr_q) + off) % NUM_CH;
      if (req_valid[cand]) grant_idx = CH_W'(cand);
    end
  end

  assign grant     = (state_q == ARB) && !freeze && (|req_valid) && !reset;
  assign req_ready = grant ? (NUM_CH'(1) << grant_idx) : '0;
  assign sample    = req_data[16*int'(grant_idx) +: 16];
  assign operand   = (sample > 16'(BCD_MAX)) ? BIN_W'(BCD_MAX) : sample[BIN_W-1:0];
  assign fsm_state = state_q;

  bin_to_bcd_seq u_conv (
    .clk     (clk),
    .reset   (reset),
    .start   (grant),
    .operand (operand),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:  if (grant) state_d = CONV;
      CONV: begin
        if (conv_done)      state_d = HOLD;
        else if (!conv_busy) state_d = ARB;
      end
      HOLD: if (cnt_q == '0) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= CH_W'(NUM_CH - 1);
      chan_pend_q <= '0;
      ovf_pend_q  <= 1'b0;
      cnt_q       <= '0;
      bcd_out     <= '0;
      chan_id     <= '0;
      overflow    <= 1'b0;
      disp_update <= 1'b0;
    end else begin
      disp_update <= 1'b0;
      if (grant) begin
        ptr_q       <= grant_idx;
        chan_pend_q <= grant_idx;
        ovf_pend_q  <= (sample > 16'(BCD_MAX));
      end
      if (state_q == CONV && conv_done) begin
        bcd_out     <= conv_bcd;
        chan_id     <= chan_pend_q;
        overflow    <= ovf_pend_q;
        disp_update <= 1'b1;
        cnt_q       <= CNT_W'(DWELL - 1);
      end else if (state_q == HOLD && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with NUM_CH=4, DWELL=8.
module tb_display_scheduler;
  import display_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DWELL  = 8;
  localparam int CH_W   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        freeze = 1'b0;
  logic [15:0] bcd_out;
  logic [2:0]  chan_id;
  logic        disp_update;
  logic        overflow;
  state_t      fsm_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  display_scheduler #(.NUM_CH(NUM_CH), .DWELL(DWELL), .CH_W(CH_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .freeze      (freeze),
    .bcd_out     (bcd_out),
    .chan_id     (chan_id),
    .disp_update (disp_update),
    .overflow    (overflow),
    .fsm_state   (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    n_vec++;
    assert ($onehot0(req_ready) && (fsm_state == ARB || req_ready == 4'b0) &&
            bcd_out[3:0] <= 4'd9 && bcd_out[7:4] <= 4'd9 &&
            bcd_out[11:8] <= 4'd9 && bcd_out[15:12] <= 4'd9) else begin
      n_err++;
      $error("FAIL invariant observed ready=%b state=%0d bcd=%h expected onehot0/ARB-only/nibbles<=9",
             req_ready, fsm_state, bcd_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string tag, output int t);
    logic found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready != 4'b0) begin
        found = 1'b1;
        t = cyc;
        break;
      end
      tick();
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    if (found) check(tag, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_update(input string tag, output int t);
    logic found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (disp_update) begin
        found = 1'b1;
        t = cyc;
        break;
      end
      tick();
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic xfer(input int ch, input logic [15:0] val, input logic [15:0] exp_bcd,
                      input logic exp_ovf, output int tg, output int tu);
    req_data[16*ch +: 16] = val;
    req_valid = 4'b0001 << ch;
    wait_grant(4'b0001 << ch, $sformatf("xfer_grant_ch%0d", ch), tg);
    tick();
    req_valid = '0;
    wait_update("xfer_update", tu);
    check("xfer_latency", 32'(tu - tg), 32'd15);
    check($sformatf("xfer_bcd_%0d", val), 32'(bcd_out), 32'(exp_bcd));
    check("xfer_chan", 32'(chan_id), 32'(ch));
    check($sformatf("xfer_ovf_%0d", val), 32'(overflow), 32'(exp_ovf));
    tick();
    #1;
    check("xfer_pulse_width", 32'(disp_update), 32'd0);
  endtask

  initial begin
    int tg, tu, tg0, tu0, tg1, tu1, upd_cnt, rdy_cnt;
    logic [3:0]  rr_ready [5];
    logic [15:0] rr_bcd [5];
    int          rr_chan [5];
    rr_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_bcd   = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0011};
    rr_chan  = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_chan", 32'(chan_id), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_update", 32'(disp_update), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ARB));

    upd_cnt = 0;
    rdy_cnt = 0;
    repeat (100) begin
      tick();
      #1;
      if (disp_update) upd_cnt++;
      if (req_ready != 4'b0) rdy_cnt++;
    end
    check("idle_updates", 32'(upd_cnt), 32'd0);
    check("idle_ready", 32'(rdy_cnt), 32'd0);
    check("idle_bcd", 32'(bcd_out), 32'h0);

    xfer(2, 16'd1234, 16'h1234, 1'b0, tg0, tu0);
    xfer(2, 16'd9999, 16'h9999, 1'b0, tg1, tu1);
    check("dwell_spacing", 32'(tg1 - tg0), 32'd23);

    req_data[31:16] = 16'd5555;
    req_valid = 4'b0010;
    wait_grant(4'b0010, "rst_mid_grant", tg);
    tick();
    req_valid = '0;
    repeat (6) tick();
    #1;
    check("rst_mid_state_conv", 32'(fsm_state), 32'(CONV));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_bcd", 32'(bcd_out), 32'h0);
    check("rst_mid_chan", 32'(chan_id), 32'd0);
    check("rst_mid_state", 32'(fsm_state), 32'(ARB));
    upd_cnt = 0;
    repeat (30) begin
      tick();
      #1;
      if (disp_update) upd_cnt++;
    end
    check("rst_mid_no_update", 32'(upd_cnt), 32'd0);

    req_data = {16'd44, 16'd33, 16'd22, 16'd11};
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(rr_ready[i], $sformatf("rr_grant_%0d", i), tg);
      tick();
      wait_update("rr_update", tu);
      check($sformatf("rr_bcd_%0d", i), 32'(bcd_out), 32'(rr_bcd[i]));
      check($sformatf("rr_chan_%0d", i), 32'(chan_id), 32'(rr_chan[i]));
    end
    req_valid = '0;

    xfer(3, 16'd10000, 16'h9999, 1'b1, tg, tu);
    xfer(3, 16'd65535, 16'h9999, 1'b1, tg, tu);
    xfer(3, 16'd0, 16'h0000, 1'b0, tg, tu);

    req_data[15:0] = 16'd42;
    req_valid = 4'b0001;
    wait_grant(4'b0001, "frz_grant", tg);
    tick();
    req_valid = 4'b0010;
    req_data[31:16] = 16'd77;
    freeze = 1'b1;
    wait_update("frz_update", tu);
    check("frz_latency", 32'(tu - tg), 32'd15);
    check("frz_bcd", 32'(bcd_out), 32'h0042);
    rdy_cnt = 0;
    repeat (40) begin
      tick();
      #1;
      if (req_ready != 4'b0) rdy_cnt++;
    end
    check("frz_no_grant", 32'(rdy_cnt), 32'd0);
    check("frz_state_arb", 32'(fsm_state), 32'(ARB));
    check("frz_bcd_held", 32'(bcd_out), 32'h0042);
    freeze = 1'b0;
    #1;
    check("frz_release_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    wait_update("frz_release_update", tu);
    check("frz_release_bcd", 32'(bcd_out), 32'h0077);
    check("frz_release_chan", 32'(chan_id), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares the single four-digit seven-segment display between NUM_CH KPN producer channels.
- Selects channels round-robin using a valid/ready handshake on each channel.
- Converts the accepted 16-bit binary sample to four BCD digits with an iterative double-dabble engine.
- Holds each result on the display for DWELL cycles, then presents it as a 16-bit packed-BCD word to the existing digit-drawing stage.

Parameters:
- NUM_CH, 4: number of producer channels (2..8).
- DWELL, 50000000: display hold time in clk cycles after each update (>=1).
- CH_W, 3: width of chan_id; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel sample available.
- req_data  in  16*NUM_CH  per-channel unsigned binary sample; channel i occupies bits [16i+15:16i].
- req_ready  out  NUM_CH  one-hot accept pulse; a transfer occurs when valid and ready are both high.
- freeze  in  1  when high, no new grants; the current display is held.
- bcd_out  out  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- chan_id  out  CH_W  channel shown on the display.
- disp_update  out  1  one-cycle pulse when bcd_out/chan_id change.
- overflow  out  1  sticky per displayed value; high when the shown sample exceeded 9999.

Behaviour:
- Reset values: bcd_out=16'h0000, chan_id=0, disp_update=0, overflow=0, req_ready=0, round-robin pointer=NUM_CH-1 (channel 0 is searched first), state=ARB.
- Reset asserted mid-operation abandons any conversion or dwell. No pending ready is issued. Outputs return to reset values on the next edge.
- ARB state:
  - If freeze=0 and any valid is high, grant the first valid channel searching from pointer+1 with wrap-around.
  - Drive req_ready for that channel only, for exactly one cycle (cycle T), combinationally from state and valid.
  - Capture req_data. Pointer := granted index. Go to CONV.
  - If no valid is high, or freeze=1, remain in ARB. Outputs hold their values.
- CONV state:
  - Sample >9999: operand := 9999 and ovf_pend := 1. Otherwise operand := sample[13:0] and ovf_pend := 0.
  - Run 14 shift-add-3 iterations, one per cycle, in cycles T+1..T+14.
  - At the end of cycle T+14, register bcd_out, chan_id and overflow := ovf_pend.
  - disp_update=1 during cycle T+15. Go to HOLD with the counter loaded to DWELL-1.
  - freeze does not interrupt CONV.
- HOLD state:
  - The counter decrements each cycle. Leave for ARB when it reaches 0.
  - First possible next grant is cycle T+15+DWELL.
  - freeze during HOLD lets the count finish, after which the block sits in ARB without granting.
- Latency: accept to disp_update is 15 cycles.
- Fairness: every continuously-valid channel is served within NUM_CH grants.
- Simultaneous events:
  - A valid that drops in the same cycle as its ready is still a transfer.
  - A valid rising in the same cycle as a grant to another channel waits for its round-robin turn.
- Invariants:
  - req_ready is zero in every non-ARB state.
  - At most one bit of req_ready is high.
  - Each BCD nibble is always <=9.

Decomposition:
- Shared package display_pkg:
  - state enum {ARB, CONV, HOLD}
  - BCD_MAX = 9999
  - BIN_W = 14
  - BCD_ITER = 14
  - Seven-segment code constants for reuse by the drawing stage.
- One sub-module, bin_to_bcd_seq:
  - Inputs: start, 14-bit operand.
  - Outputs: busy, done pulse, 16-bit BCD.
  - Fixed 14-cycle latency.
- The arbiter, dwell counter and FSM stay in display_scheduler.

Test Plan:
- Reset then idle: no valid for 100 cycles -> bcd_out=0000, chan_id=0, req_ready=0, disp_update never pulses.
- Single channel (NUM_CH=4, DWELL=8): ch2 valid with 1234 at cycle T -> req_ready=4'b0100 only at T; disp_update at T+15; bcd_out=16'h1234, chan_id=2; next grant no earlier than T+23.
- Round-robin: all four channels valid continuously with values 11, 22, 33, 44 -> grant order 0,1,2,3,0; displayed words 0011, 0022, 0033, 0044, 0011.
- Saturation and boundaries:
  - 9999 -> bcd_out=9999, overflow=0.
  - 10000 -> bcd_out=9999, overflow=1.
  - 65535 -> bcd_out=9999, overflow=1.
  - 0 -> bcd_out=0000, overflow=0.
- freeze: assert freeze during CONV of 0042 -> update to 0042 still occurs; with ch1 valid, no grant for the whole freeze period; release -> grant within 1 cycle.
- Reset mid-CONV at T+7 -> no disp_update follows; outputs return to 0; pointer restarts at channel 0.
